// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: byte queue between a UART receiver and a bus-side reader.
//
// A rising edge of rx_valid captures rx_data into the queue and answers the
// receiver with a single-cycle rx_val_set pulse. The bus side sees the head
// byte on rd_data (show-ahead) and pops it with rd_en. If a byte arrives
// while the queue is full and no pop frees a slot, the byte is dropped and
// the sticky overflow flag is raised.
//
// Ports
//   clk, rst    : clock; synchronous active-high reset
//   rx_data     : byte from the receiver
//   rx_valid    : receiver data-valid (edge-detected)
//   rx_val_set  : one-cycle acknowledge after every capture event
//   rd_en       : pop request
//   rd_data     : head-of-queue byte
//   empty, full : queue status, derived from the registered count
//   count       : stored bytes, 0..DEPTH
//   level       : interrupt threshold (0 disables the interrupt)
//   thr_irq     : high while count >= level
//   overflow    : sticky byte-lost flag
//   ovf_clr     : clears overflow
//   flush       : discards all stored bytes
module uart_rx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic          rx_val_set,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  input  logic [CW-1:0] level,
  output logic          thr_irq,
  output logic          overflow,
  input  logic          ovf_clr,
  input  logic          flush
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          rx_valid_q;
  logic          ovf;
  logic          val_set;

  logic          cap;
  logic          pop;
  logic          push;
  logic          drop;
  logic [CW-1:0] cnt_next;

  // A capture is the low-to-high transition of rx_valid. The history bit
  // resets high so a level held through reset does not count as an edge.
  assign cap  = rx_valid & ~rx_valid_q;
  assign pop  = rd_en & ~empty;
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  always_comb begin
    cnt_next = cnt;
    case ({push, pop})
      2'b10:   cnt_next = cnt + CW'(1);
      2'b01:   cnt_next = cnt - CW'(1);
      default: cnt_next = cnt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      rx_valid_q <= 1'b1;
      ovf        <= 1'b0;
      val_set    <= 1'b0;
    end else begin
      rx_valid_q <= rx_valid;
      // The acknowledge goes out even when flush discards the byte.
      val_set    <= cap;
      if (drop)
        ovf <= 1'b1;
      else if (ovf_clr)
        ovf <= 1'b0;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        // DEPTH is a power of two, so plain increment wraps with no gap.
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        cnt <= cnt_next;
      end
    end
  end

  // Storage carries no reset; stale contents are never visible because the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst)
      mem[wr_ptr] <= rx_data;
  end

  assign rd_data    = mem[rd_ptr];
  assign count      = cnt;
  assign empty      = (cnt == '0);
  assign full       = (cnt == CW'(DEPTH));
  assign thr_irq    = (level != '0) && (cnt >= level);
  assign overflow   = ovf;
  assign rx_val_set = val_set;

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 8;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          rx_val_set;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          empty;
  logic          full;
  logic [CW-1:0] count;
  logic [CW-1:0] level = '0;
  logic          thr_irq;
  logic          overflow;
  logic          ovf_clr = 1'b0;
  logic          flush = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: a queue of bytes plus the few flags the rules define.
  logic [7:0] q[$];
  bit         m_ovf  = 1'b0;
  bit         m_prev = 1'b1;
  bit         m_vs   = 1'b0;

  uart_rx_fifo #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_val_set(rx_val_set), .rd_en(rd_en), .rd_data(rd_data),
    .empty(empty), .full(full), .count(count), .level(level),
    .thr_irq(thr_irq), .overflow(overflow), .ovf_clr(ovf_clr), .flush(flush)
  );

  always #5 clk = ~clk;

  function automatic bit exp_thr();
    return (level != 0) && (q.size() >= int'(level));
  endfunction

  // Apply one cycle of inputs, advance the model by the same rules, and
  // return #1 after the clock edge so outputs can be sampled.
  task automatic step(input logic v, input logic [7:0] d, input logic r,
                      input logic f, input logic c);
    bit cap, popok, drop;
    int n;
    rx_valid = v; rx_data = d; rd_en = r; flush = f; ovf_clr = c;
    n     = q.size();
    cap   = v && !m_prev;
    popok = r && (n > 0);
    drop  = cap && (n == DEPTH) && !popok;
    if (rst) begin
      q.delete(); m_ovf = 0; m_prev = 1; m_vs = 0;
    end else begin
      m_vs   = cap;
      m_prev = v;
      if (f) q.delete();
      else begin
        if (popok) void'(q.pop_front());
        if (cap && !drop) q.push_back(d);
      end
      if (drop) m_ovf = 1;
      else if (c) m_ovf = 0;
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d);
    step(1'b1, d, 1'b0, 1'b0, 1'b0);
    idle();
  endtask

  task automatic pop_one();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    rst = 1'b0;
    idle();
  endtask

  task automatic test_reset();
    level = CW'(1);
    rst = 1'b1;
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_count: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b want 1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b want 0", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", overflow); end
    n_cmp++; if (rx_val_set !== 1'b0) begin n_err++; $display("FAIL reset_valset: got %b want 0", rx_val_set); end
    n_cmp++; if (thr_irq !== 1'b0) begin n_err++; $display("FAIL reset_thr: got %b want 0", thr_irq); end
    rst = 1'b0;
    // rx_valid still high after reset: no capture must occur.
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h77, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (rx_val_set !== 1'b0) begin n_err++; $display("FAIL reset_held_valid_ack: got %b want 0", rx_val_set); end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL reset_held_valid_count: got %0d want 0", count); end
    idle();
    level = '0;
  endtask

  task automatic test_basic();
    logic [7:0] bytes [3];
    int pulses;
    bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, bytes[i], 1'b0, 1'b0, 1'b0);
      if (rx_val_set === 1'b1) pulses++;
      idle();
      if (rx_val_set === 1'b1) pulses++;
    end
    n_cmp++; if (pulses != 3) begin n_err++; $display("FAIL basic_ack_pulses: got %0d want 3", pulses); end
    n_cmp++; if (count !== CW'(3)) begin n_err++; $display("FAIL basic_count3: got %0d want 3", count); end
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (rd_data !== bytes[i]) begin n_err++; $display("FAIL basic_rd_data[%0d]: got %h want %h", i, rd_data, bytes[i]); end
      pop_one();
    end
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL basic_count0: got %0d want 0", count); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty: got %b want 1", empty); end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'(i));
    n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full_after8: got %b want 1", full); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_before9: got %b want 0", overflow); end
    step(1'b1, 8'h08, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_after9: got %b want 1", overflow); end
    n_cmp++; if (rx_val_set !== 1'b1) begin n_err++; $display("FAIL ovf_drop_ack: got %b want 1", rx_val_set); end
    idle();
    for (int i = 0; i < 8; i++) begin
      n_cmp++; if (rd_data !== 8'(i)) begin n_err++; $display("FAIL ovf_pop[%0d]: got %h want %h", i, rd_data, 8'(i)); end
      pop_one();
    end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL ovf_empty_end: got %b want 1", empty); end
  endtask

  task automatic test_full_simul();
    logic [7:0] last;
    do_reset();
    for (int i = 0; i < 8; i++) send_byte(8'h10 + 8'(i));
    step(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (count !== CW'(8)) begin n_err++; $display("FAIL simul_count: got %0d want 8", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL simul_ovf: got %b want 0", overflow); end
    idle();
    last = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last = rd_data;
      pop_one();
    end
    n_cmp++; if (last !== 8'hA5) begin n_err++; $display("FAIL simul_last_byte: got %h want a5", last); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL simul_empty: got %b want 1", empty); end
  endtask

  task automatic test_held_valid();
    int pulses;
    do_reset();
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
      if (rx_val_set === 1'b1) pulses++;
    end
    idle();
    if (rx_val_set === 1'b1) pulses++;
    n_cmp++; if (pulses != 1) begin n_err++; $display("FAIL held_ack_pulses: got %0d want 1", pulses); end
    n_cmp++; if (count !== CW'(1)) begin n_err++; $display("FAIL held_count: got %0d want 1", count); end
    n_cmp++; if (rd_data !== 8'h5A) begin n_err++; $display("FAIL held_rd_data: got %h want 5a", rd_data); end
  endtask

  task automatic test_threshold();
    logic [2:0] seen;
    do_reset();
    level = CW'(3);
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hC0 + 8'(i), 1'b0, 1'b0, 1'b0);
      seen[i] = thr_irq;
      idle();
    end
    n_cmp++; if (seen !== 3'b100) begin n_err++; $display("FAIL thr_rise: got %b want 100", seen); end
    pop_one();
    n_cmp++; if (thr_irq !== 1'b0) begin n_err++; $display("FAIL thr_fall: got %b want 0", thr_irq); end
    level = '0;
    idle();
    idle();
    send_byte(8'hC9);
    n_cmp++; if (thr_irq !== 1'b0) begin n_err++; $display("FAIL thr_level0: got %b want 0", thr_irq); end
  endtask

  task automatic test_flush_reset();
    do_reset();
    for (int i = 0; i < 9; i++) send_byte(8'h40 + 8'(i));
    for (int i = 0; i < 4; i++) pop_one();
    n_cmp++; if (count !== CW'(4) || overflow !== 1'b1) begin n_err++; $display("FAIL flush_setup: got count %0d ovf %b want 4 1", count, overflow); end
    step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    n_cmp++; if (count !== '0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count); end
    n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL flush_ovf_clr: got %b want 0", overflow); end
    rst = 1'b1;
    idle();
    rst = 1'b0;
    n_cmp++; if (empty !== 1'b1 || full !== 1'b0 || rx_val_set !== 1'b0) begin n_err++; $display("FAIL flush_rst_flags: got e%b f%b a%b want e1 f0 a0", empty, full, rx_val_set); end
    pop_one();
    n_cmp++; if (count !== '0 || empty !== 1'b1 || overflow !== 1'b0) begin n_err++; $display("FAIL flush_pop_ignored: got c%0d e%b o%b want c0 e1 o0", count, empty, overflow); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) level = CW'($urandom_range(0, DEPTH));
      step(($urandom_range(0, 99) < 45), 8'($urandom), ($urandom_range(0, 99) < 25),
           ($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0));
      n_cmp++; if (count !== CW'(q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", i, count, q.size()); end
      n_cmp++; if (empty !== (q.size() == 0) || full !== (q.size() == DEPTH)) begin n_err++; $display("FAIL rnd_flags@%0d: got e%b f%b want size %0d", i, empty, full, q.size()); end
      n_cmp++; if (overflow !== m_ovf) begin n_err++; $display("FAIL rnd_ovf@%0d: got %b want %b", i, overflow, m_ovf); end
      n_cmp++; if (rx_val_set !== m_vs) begin n_err++; $display("FAIL rnd_ack@%0d: got %b want %b", i, rx_val_set, m_vs); end
      n_cmp++; if (thr_irq !== exp_thr()) begin n_err++; $display("FAIL rnd_thr@%0d: got %b want %b", i, thr_irq, exp_thr()); end
      if (q.size() > 0) begin
        n_cmp++; if (rd_data !== q[0]) begin n_err++; $display("FAIL rnd_rd_data@%0d: got %h want %h", i, rd_data, q[0]); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_full_simul();
    test_held_valid();
    test_threshold();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
